// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing defaults, coordinate type and segment enum
package vga_timing_pkg;
    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    typedef logic [9:0] coord_t;
    typedef enum logic [1:0] {SEG_VIS, SEG_FP, SEG_SYNC, SEG_BP} seg_t;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; position counter plus VIS/FP/SYNC/BP segment FSM
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VIS  = H_VIS,
    parameter int FP   = H_FP,
    parameter int SYNC = H_SYNC,
    parameter int BP   = H_BP
) (
    input  logic   Clk,
    input  logic   Reset,
    input  logic   adv,
    output coord_t count,
    output seg_t   seg,
    output logic   wrap,
    output logic   sync_n
);
    localparam coord_t END_VIS  = coord_t'(VIS - 1);
    localparam coord_t END_FP   = coord_t'(VIS + FP - 1);
    localparam coord_t END_SYNC = coord_t'(VIS + FP + SYNC - 1);
    localparam coord_t LAST     = coord_t'(VIS + FP + SYNC + BP - 1);

    seg_t seg_nx;

    assign wrap   = adv && count == LAST;
    assign sync_n = seg != SEG_SYNC;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
            seg   <= SEG_VIS;
        end else begin
            seg <= seg_nx;
            if (adv) count <= wrap ? '0 : count + 1'b1;
        end
    end

    // Segment moves on the same advance that moves the count past a boundary
    always_comb begin
        seg_nx = seg;
        if (adv)
            unique case (seg)
                SEG_VIS:  seg_nx = count == END_VIS  ? SEG_FP   : SEG_VIS;
                SEG_FP:   seg_nx = count == END_FP   ? SEG_SYNC : SEG_FP;
                SEG_SYNC: seg_nx = count == END_SYNC ? SEG_BP   : SEG_SYNC;
                SEG_BP:   seg_nx = wrap              ? SEG_VIS  : SEG_BP;
            endcase
    end
endmodule

// File: rtl/vga_raster_timer.sv
// vga_raster_timer: 640x480@60 raster generator (pixel clock, scan position, syncs, strobes)
module vga_raster_timer
    import vga_timing_pkg::*;
#(
    parameter int H_VIS  = vga_timing_pkg::H_VIS,
    parameter int H_FP   = vga_timing_pkg::H_FP,
    parameter int H_SYNC = vga_timing_pkg::H_SYNC,
    parameter int H_BP   = vga_timing_pkg::H_BP,
    parameter int V_VIS  = vga_timing_pkg::V_VIS,
    parameter int V_FP   = vga_timing_pkg::V_FP,
    parameter int V_SYNC = vga_timing_pkg::V_SYNC,
    parameter int V_BP   = vga_timing_pkg::V_BP
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_clk,
    output logic       pix_en,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);
    logic ph, h_wrap, v_wrap;
    seg_t h_seg, v_seg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ph          <= 1'b0;
            frame_count <= '0;
        end else begin
            ph <= ~ph;
            if (v_wrap) frame_count <= frame_count + 1'b1;
        end
    end

    vga_axis_counter #(.VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .Clk(Clk), .Reset(Reset), .adv(ph), .count(DrawX), .seg(h_seg), .wrap(h_wrap), .sync_n(hs)
    );

    // Vertical axis steps once per completed line
    vga_axis_counter #(.VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .Clk(Clk), .Reset(Reset), .adv(h_wrap), .count(DrawY), .seg(v_seg), .wrap(v_wrap), .sync_n(vs)
    );

    assign pixel_clk   = ph;
    assign pix_en      = ph;
    assign blank       = h_seg == SEG_VIS && v_seg == SEG_VIS;
    assign sync        = 1'b0;
    assign line_start  = ph && DrawX == '0;
    assign frame_start = line_start && DrawY == '0;
endmodule

// File: tb/tb_vga_raster_timer.sv
// tb_vga_raster_timer: full-size and reduced-parameter DUTs checked every Clk against an arithmetic raster model
module tb_vga_raster_timer;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #10 Clk = ~Clk;

    logic f_pclk, f_pen, f_hs, f_vs, f_blank, f_sync, f_ls, f_fs;
    logic [9:0] f_x, f_y;
    logic [7:0] f_fc;
    logic s_pclk, s_pen, s_hs, s_vs, s_blank, s_sync, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic [7:0] s_fc;

    vga_raster_timer dut_f (
        .Clk(Clk), .Reset(Reset), .pixel_clk(f_pclk), .pix_en(f_pen), .DrawX(f_x), .DrawY(f_y),
        .hs(f_hs), .vs(f_vs), .blank(f_blank), .sync(f_sync), .line_start(f_ls),
        .frame_start(f_fs), .frame_count(f_fc)
    );

    vga_raster_timer #(
        .H_VIS(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_s (
        .Clk(Clk), .Reset(Reset), .pixel_clk(s_pclk), .pix_en(s_pen), .DrawX(s_x), .DrawY(s_y),
        .hs(s_hs), .vs(s_vs), .blank(s_blank), .sync(s_sync), .line_start(s_ls),
        .frame_start(s_fs), .frame_count(s_fc)
    );

    logic [35:0] f_vec, s_vec;
    assign f_vec = {f_pclk, f_pen, f_x, f_y, f_hs, f_vs, f_blank, f_sync, f_ls, f_fs, f_fc};
    assign s_vec = {s_pclk, s_pen, s_x, s_y, s_hs, s_vs, s_blank, s_sync, s_ls, s_fs, s_fc};

    int t = 0;
    int errs = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // t = Clk edges since reset released; every pixel spans two edges
    always @(posedge Clk) t <= Reset ? 0 : t + 1;

    function automatic logic [35:0] model(int tt, int hv, int hf, int hsw, int hb, int vv, int vf, int vsw, int vb);
        int ht, vt, p, hc, vc, fc;
        logic ph, ls, hsn, vsn, bl;
        ht  = hv + hf + hsw + hb;
        vt  = vv + vf + vsw + vb;
        p   = tt / 2;
        ph  = tt % 2 == 1;
        hc  = p % ht;
        vc  = (p / ht) % vt;
        fc  = (p / (ht * vt)) % 256;
        hsn = !(hc >= hv + hf && hc < hv + hf + hsw);
        vsn = !(vc >= vv + vf && vc < vv + vf + vsw);
        bl  = hc < hv && vc < vv;
        ls  = ph && hc == 0;
        return {ph, ph, hc[9:0], vc[9:0], hsn, vsn, bl, 1'b0, ls, ls && vc == 0, fc[7:0]};
    endfunction

    task automatic check(string name, logic [35:0] act, logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s t=%0d actual=%h expected=%h", name, t, act, exp);
        end
    endtask

    task automatic lit(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s t=%0d actual=%0d expected=%0d", name, t, act, exp);
        end
    endtask

    task automatic run_to(int n);
        repeat (n - t) @(negedge Clk);
    endtask

    always @(negedge Clk) begin
        if (chk_on) begin
            check("full", f_vec, model(t, 640, 16, 96, 48, 480, 10, 2, 33));
            check("small", s_vec, model(t, 8, 1, 2, 1, 4, 1, 1, 1));
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge Clk);
        chk_on = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        lit("rst_x", f_x, 0);
        lit("rst_hs", f_hs, 1);
        lit("rst_vs", f_vs, 1);
        lit("rst_blank", f_blank, 1);
        lit("rst_pen", f_pen, 0);
        lit("rst_fc", f_fc, 0);
        Reset = 1'b0;
        @(negedge Clk);
        lit("t1_pen", f_pen, 1);
        lit("t1_ls", f_ls, 1);
        lit("t1_fs", f_fs, 1);
        lit("t1_x", f_x, 0);
        @(negedge Clk);
        lit("t2_x", f_x, 1);
        run_to(1280);
        lit("blank_640", f_blank, 0);
        run_to(1311);
        lit("hs_655", f_hs, 1);
        run_to(1312);
        lit("hs_656", f_hs, 0);
        lit("x_656", f_x, 656);
        run_to(1503);
        lit("hs_751", f_hs, 0);
        run_to(1504);
        lit("hs_752", f_hs, 1);
        run_to(1599);
        lit("ls_799", f_ls, 0);
        run_to(1601);
        lit("ls_line1", f_ls, 1);
        lit("y_line1", f_y, 1);
        run_to(3000);
        lit("x_700", f_x, 700);
        lit("s_fc_mid", s_fc, 17);
        Reset = 1'b1;
        @(negedge Clk);
        lit("mid_x", f_x, 0);
        lit("mid_y", f_y, 0);
        lit("mid_hs", f_hs, 1);
        lit("mid_blank", f_blank, 1);
        lit("mid_pclk", f_pclk, 0);
        lit("mid_sfc", s_fc, 0);
        Reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(1, 4000)) @(negedge Clk);
            Reset = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge Clk);
            Reset = 1'b0;
        end
        run_to(43007);
        lit("s_fc_255", s_fc, 255);
        lit("s_x_last", s_x, 11);
        lit("s_y_last", s_y, 6);
        run_to(43008);
        lit("s_fc_wrap", s_fc, 0);
        lit("s_x_wrap", s_x, 0);
        lit("s_y_wrap", s_y, 0);
        lit("s_blank_wrap", s_blank, 1);
        run_to(43009);
        lit("s_fs_wrap", s_fs, 1);
        run_to(43128);
        lit("s_vs_y5", s_vs, 0);
        run_to(43152);
        lit("s_vs_y6", s_vs, 1);
        repeat (4) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
